// File: rtl/i2c_target_fifo.sv
// I2C target with a write-data FIFO and a read-data FIFO.
// scl/sda are oversampled on clk_i. START, repeated START and STOP are
// detected in every state and take priority over bit events. Bytes written
// by the master land in the write FIFO. Bytes read by the master come from
// the read FIFO, or are all-ones when that FIFO is empty.
module i2c_target_fifo #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int WR_FIFO_DEPTH  = 8,
  parameter int RD_FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe_o,
  input  logic [I2C_ADDR_WIDTH-1:0] target_addr_i,
  output logic [I2C_DATA_WIDTH-1:0] wr_rdata_o,
  output logic                      wr_empty_o,
  input  logic                      wr_pop_i,
  input  logic [I2C_DATA_WIDTH-1:0] rd_wdata_i,
  input  logic                      rd_push_i,
  output logic                      rd_full_o,
  output logic                      busy_o,
  output logic                      op_o,
  output logic                      xfer_done_o,
  output logic                      wr_overflow_o,
  output logic                      rd_underflow_o
);

  localparam int AW  = I2C_ADDR_WIDTH;
  localparam int DW  = I2C_DATA_WIDTH;
  localparam int NB  = (AW + 1 > DW) ? AW + 1 : DW;
  localparam int CW  = $clog2(NB + 1);
  localparam int WAW = $clog2(WR_FIFO_DEPTH);
  localparam int RAW = $clog2(RD_FIFO_DEPTH);
  localparam logic [CW-1:0]  ABITS   = CW'(AW + 1);
  localparam logic [CW-1:0]  DBITS   = CW'(DW);
  localparam logic [WAW:0]   WR_DEPTH = (WAW+1)'(WR_FIFO_DEPTH);
  localparam logic [RAW:0]   RD_DEPTH = (RAW+1)'(RD_FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, RD_WAIT, IGNORE
  } state_t;

  // ---------------- input synchronizers + edge detect ----------------
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Sync chains reset to the idle-bus level so reset release cannot fake an event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  logic rise, fall, start, stop, bus_evt;
  assign rise    = scl_s & ~scl_q;
  assign fall    = ~scl_s & scl_q;
  assign start   = scl_s & scl_q & sda_q & ~sda_s;
  assign stop    = scl_s & scl_q & ~sda_q & sda_s;
  assign bus_evt = start | stop;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [AW:0]    ashift;
  logic [DW-1:0]  shreg;

  // ---------------- write FIFO ----------------
  logic [DW-1:0]  wr_mem [WR_FIFO_DEPTH];
  logic [WAW-1:0] wr_wp, wr_rp;
  logic [WAW:0]   wr_cnt;
  logic           wr_full, wr_push, wr_pop;

  assign wr_full    = (wr_cnt == WR_DEPTH);
  assign wr_empty_o = (wr_cnt == '0);
  assign wr_rdata_o = wr_mem[wr_rp];
  assign wr_push    = ~bus_evt & (state == WR_DATA) & fall & (cnt == DBITS) & ~wr_full;
  assign wr_pop     = wr_pop_i & ~wr_empty_o;

  // Write FIFO storage and pointers; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < WR_FIFO_DEPTH; i++) wr_mem[i] <= '0;
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (wr_push) begin
        wr_mem[wr_wp] <= shreg;
        wr_wp         <= wr_wp + 1'b1;
      end
      if (wr_pop) wr_rp <= wr_rp + 1'b1;
      case ({wr_push, wr_pop})
        2'b10:   wr_cnt <= wr_cnt + 1'b1;
        2'b01:   wr_cnt <= wr_cnt - 1'b1;
        default: wr_cnt <= wr_cnt;
      endcase
    end
  end

  // ---------------- read FIFO ----------------
  logic [DW-1:0]  rd_mem [RD_FIFO_DEPTH];
  logic [RAW-1:0] rd_wp, rd_rp;
  logic [RAW:0]   rd_cnt;
  logic           rd_empty, rd_push, rd_take, rd_pop;
  logic [DW-1:0]  rd_byte;

  assign rd_full_o = (rd_cnt == RD_DEPTH);
  assign rd_empty  = (rd_cnt == '0);
  assign rd_push   = rd_push_i & ~rd_full_o;
  // The FSM needs a new byte when a READ address is ACKed or the master ACKs a byte.
  assign rd_take   = ~bus_evt & (((state == ADDR_ACK) & fall & op_o) |
                                 ((state == RD_ACK) & rise & ~sda_s));
  assign rd_pop    = rd_take & ~rd_empty;
  assign rd_byte   = rd_empty ? '1 : rd_mem[rd_rp];

  // Read FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) rd_mem[i] <= '0;
      rd_wp  <= '0;
      rd_rp  <= '0;
      rd_cnt <= '0;
    end else begin
      if (rd_push) begin
        rd_mem[rd_wp] <= rd_wdata_i;
        rd_wp         <= rd_wp + 1'b1;
      end
      if (rd_pop) rd_rp <= rd_rp + 1'b1;
      case ({rd_push, rd_pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // ---------------- protocol FSM ----------------
  // Bits are taken on scl rising edges; sda is changed only on falling edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      cnt            <= '0;
      ashift         <= '0;
      shreg          <= '0;
      sda_oe_o       <= 1'b0;
      busy_o         <= 1'b0;
      op_o           <= 1'b0;
      xfer_done_o    <= 1'b0;
      wr_overflow_o  <= 1'b0;
      rd_underflow_o <= 1'b0;
    end else begin
      xfer_done_o    <= 1'b0;
      wr_overflow_o  <= 1'b0;
      rd_underflow_o <= 1'b0;
      if (bus_evt) begin
        xfer_done_o <= busy_o;
        busy_o      <= 1'b0;
        sda_oe_o    <= 1'b0;
        cnt         <= '0;
        state       <= start ? ADDR : IDLE;
      end else begin
        case (state)
          ADDR: begin
            if (rise) begin
              ashift <= {ashift[AW-1:0], sda_s};
              cnt    <= cnt + 1'b1;
            end else if (fall && cnt == ABITS) begin
              cnt <= '0;
              if (ashift[AW:1] == target_addr_i) begin
                state    <= ADDR_ACK;
                busy_o   <= 1'b1;
                op_o     <= ashift[0];
                sda_oe_o <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (fall) begin
              if (op_o) begin
                // First read bit goes out on the same edge that ends the ACK.
                shreg          <= {rd_byte[DW-2:0], 1'b0};
                sda_oe_o       <= ~rd_byte[DW-1];
                rd_underflow_o <= rd_empty;
                cnt            <= CW'(1);
                state          <= RD_DATA;
              end else begin
                sda_oe_o <= 1'b0;
                cnt      <= '0;
                state    <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (rise && cnt != DBITS) begin
              shreg <= {shreg[DW-2:0], sda_s};
              cnt   <= cnt + 1'b1;
            end else if (fall && cnt == DBITS) begin
              sda_oe_o      <= ~wr_full;
              wr_overflow_o <= wr_full;
              state         <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (fall) begin
              sda_oe_o <= 1'b0;
              cnt      <= '0;
              state    <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (fall) begin
              if (cnt == DBITS) begin
                sda_oe_o <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sda_oe_o <= ~shreg[DW-1];
                shreg    <= {shreg[DW-2:0], 1'b0};
                cnt      <= cnt + 1'b1;
              end
            end
          end
          RD_ACK: begin
            if (rise) begin
              if (!sda_s) begin
                shreg          <= rd_byte;
                rd_underflow_o <= rd_empty;
                cnt            <= '0;
                state          <= RD_DATA;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
          IDLE, RD_WAIT, IGNORE: state <= state;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Bench for i2c_target_fifo: a bit-banged I2C master drives a table of bus
// operations and checks ACKs, read data, FIFO contents and pulse counts.
module tb_i2c_target_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_oe;
  logic [6:0] target_addr = 7'h22;
  logic [7:0] wr_rdata;
  logic       wr_empty;
  logic       wr_pop = 1'b0;
  logic [7:0] rd_wdata = 8'h00;
  logic       rd_push = 1'b0;
  logic       rd_full, busy, op, xfer_done, wr_overflow, rd_underflow;
  logic       sda_line;

  assign sda_line = msda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_fifo dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .target_addr_i(target_addr),
    .wr_rdata_o(wr_rdata), .wr_empty_o(wr_empty), .wr_pop_i(wr_pop),
    .rd_wdata_i(rd_wdata), .rd_push_i(rd_push), .rd_full_o(rd_full),
    .busy_o(busy), .op_o(op), .xfer_done_o(xfer_done),
    .wr_overflow_o(wr_overflow), .rd_underflow_o(rd_underflow)
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_ovf = 0, n_und = 0;
  logic oe_seen = 1'b0;

  // Pulse counters and a sticky record of any sda drive.
  always @(posedge clk) begin
    if (xfer_done)    n_done = n_done + 1;
    if (wr_overflow)  n_ovf  = n_ovf + 1;
    if (rd_underflow) n_und  = n_und + 1;
    if (sda_oe)       oe_seen = 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One scl period: data set mid-low, sample mid-high.
  task automatic bit_cycle(input logic b, output logic s);
    msda = b; wc(5);
    scl = 1'b1; wc(5);
    s = sda_line; wc(5);
    scl = 1'b0; wc(5);
  endtask

  task automatic i2c_start();
    msda = 1'b1; scl = 1'b1; wc(10);
    msda = 1'b0; wc(10);
    scl = 1'b0; wc(5);
  endtask

  task automatic i2c_rstart();
    msda = 1'b1; wc(5);
    scl = 1'b1; wc(10);
    msda = 1'b0; wc(10);
    scl = 1'b0; wc(5);
  endtask

  task automatic i2c_stop();
    msda = 1'b0; wc(5);
    scl = 1'b1; wc(10);
    msda = 1'b1; wc(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      d = {d[6:0], s};
    end
    bit_cycle(nack, s);
  endtask

  task automatic push_rd(input logic [7:0] d);
    rd_wdata = d; rd_push = 1'b1; wc(1);
    rd_push = 1'b0;
  endtask

  task automatic pop_wr();
    wr_pop = 1'b1; wc(1);
    wr_pop = 1'b0;
  endtask

  localparam int OP_START = 0, OP_RSTART = 1, OP_STOP = 2, OP_WR = 3, OP_RD = 4,
                 OP_POP = 5, OP_CHK = 6, OP_CNT = 7, OP_PUSH = 8, OP_NOOE = 9;

  // e: OP_WR ack; OP_RD byte; OP_POP head; OP_CHK {sda_oe,busy,op,wr_empty};
  //    OP_CNT {done[1:0],ovf[1:0],und[1:0]} in bits [5:0]; OP_NOOE oe_seen.
  typedef struct {
    int         op;
    logic [7:0] d;
    logic       a;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int o, input logic [7:0] d, input logic a, input logic [7:0] e);
    vec_t v;
    v.op = o; v.d = d; v.a = a; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic [7:0] exp_b;

    // Write 0xA5,0x3C,0xFF to address 0x22
    add(OP_START, 0, 0, 0);
    add(OP_WR, 8'h44, 0, 1);
    add(OP_CHK, 0, 0, 8'h5);
    add(OP_WR, 8'hA5, 0, 1);
    add(OP_WR, 8'h3C, 0, 1);
    add(OP_WR, 8'hFF, 0, 1);
    add(OP_STOP, 0, 0, 0);
    add(OP_CHK, 0, 0, 8'h0);
    add(OP_POP, 0, 0, 8'hA5);
    add(OP_POP, 0, 0, 8'h3C);
    add(OP_POP, 0, 0, 8'hFF);
    add(OP_CHK, 0, 0, 8'h1);
    add(OP_CNT, 0, 0, 8'h10);
    // Address 0x23 is not ours: never drive sda
    add(OP_START, 0, 0, 0);
    add(OP_WR, 8'h46, 0, 0);
    add(OP_WR, 8'h11, 0, 0);
    add(OP_STOP, 0, 0, 0);
    add(OP_CHK, 0, 0, 8'h1);
    add(OP_NOOE, 0, 0, 0);
    add(OP_CNT, 0, 0, 8'h00);
    // Read two preloaded bytes, ACK then NACK
    add(OP_PUSH, 8'h5A, 0, 0);
    add(OP_PUSH, 8'hC3, 0, 0);
    add(OP_START, 0, 0, 0);
    add(OP_WR, 8'h45, 0, 1);
    add(OP_CHK, 0, 0, 8'hF);
    add(OP_RD, 0, 0, 8'h5A);
    add(OP_RD, 0, 1, 8'hC3);
    add(OP_CHK, 0, 0, 8'h7);
    add(OP_STOP, 0, 0, 0);
    add(OP_CHK, 0, 0, 8'h1);
    add(OP_CNT, 0, 0, 8'h10);
    // Write, repeated START, read from an empty FIFO
    add(OP_START, 0, 0, 0);
    add(OP_WR, 8'h44, 0, 1);
    add(OP_CHK, 0, 0, 8'h5);
    add(OP_WR, 8'h01, 0, 1);
    add(OP_RSTART, 0, 0, 0);
    add(OP_CNT, 0, 0, 8'h10);
    add(OP_WR, 8'h45, 0, 1);
    add(OP_CHK, 0, 0, 8'h6);
    add(OP_RD, 0, 1, 8'hFF);
    add(OP_STOP, 0, 0, 0);
    add(OP_CNT, 0, 0, 8'h11);
    add(OP_POP, 0, 0, 8'h01);
    add(OP_CHK, 0, 0, 8'h1);

    // Reset state
    wc(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op", op, 0);
    chk("rst_wr_empty", wr_empty, 1);
    chk("rst_rd_full", rd_full, 0);
    chk("rst_wr_rdata", wr_rdata, 0);
    chk("rst_pulses", {xfer_done, wr_overflow, rd_underflow}, 0);
    rst_n = 1'b1;
    wc(5);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_START:  i2c_start();
        OP_RSTART: i2c_rstart();
        OP_STOP:   i2c_stop();
        OP_PUSH:   push_rd(tbl[i].d);
        OP_WR: begin
          write_byte(tbl[i].d, ack);
          chk($sformatf("v%0d_ack", i), ack, tbl[i].e[0]);
        end
        OP_RD: begin
          read_byte(tbl[i].a, rb);
          chk($sformatf("v%0d_rd_byte", i), rb, tbl[i].e);
        end
        OP_POP: begin
          chk($sformatf("v%0d_not_empty", i), wr_empty, 0);
          chk($sformatf("v%0d_wr_head", i), wr_rdata, tbl[i].e);
          pop_wr();
        end
        OP_CHK: begin
          chk($sformatf("v%0d_sda_oe", i), sda_oe, tbl[i].e[3]);
          chk($sformatf("v%0d_busy", i), busy, tbl[i].e[2]);
          if (tbl[i].e[2]) chk($sformatf("v%0d_op", i), op, tbl[i].e[1]);
          chk($sformatf("v%0d_wr_empty", i), wr_empty, tbl[i].e[0]);
        end
        OP_CNT: begin
          chk($sformatf("v%0d_n_done", i), n_done, tbl[i].e[5:4]);
          chk($sformatf("v%0d_n_ovf", i), n_ovf, tbl[i].e[3:2]);
          chk($sformatf("v%0d_n_und", i), n_und, tbl[i].e[1:0]);
          n_done = 0; n_ovf = 0; n_und = 0; oe_seen = 1'b0;
        end
        OP_NOOE: chk($sformatf("v%0d_oe_seen", i), oe_seen, tbl[i].e[0]);
        default: ;
      endcase
    end

    // Nine writes into an eight-entry FIFO: the ninth is NACKed and dropped
    n_done = 0; n_ovf = 0; n_und = 0;
    i2c_start();
    write_byte(8'h44, ack);
    chk("ovf_addr_ack", ack, 1);
    for (int i = 1; i <= 9; i++) begin
      exp_b = 8'(i * 17);
      write_byte(exp_b, ack);
      chk($sformatf("ovf_ack%0d", i), ack, (i <= 8) ? 1 : 0);
    end
    i2c_stop();
    chk("ovf_pulses", n_ovf, 1);
    chk("ovf_done", n_done, 1);
    for (int i = 1; i <= 8; i++) begin
      exp_b = 8'(i * 17);
      chk($sformatf("ovf_head%0d", i), wr_rdata, exp_b);
      pop_wr();
    end
    chk("ovf_empty_after", wr_empty, 1);

    // Reset while driving a zero data bit
    for (int i = 0; i < 8; i++) push_rd(8'h00);
    chk("rd_full", rd_full, 1);
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h77, ack);
    i2c_rstart();
    write_byte(8'h45, ack);
    chk("mid_sda_oe", sda_oe, 1);
    chk("mid_wr_not_empty", wr_empty, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sda_oe", sda_oe, 0);
    chk("async_busy", busy, 0);
    scl = 1'b1; msda = 1'b1;
    wc(3);
    rst_n = 1'b1;
    wc(5);
    chk("post_rst_wr_empty", wr_empty, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rd_full", rd_full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
